// File: rtl/load_store_unit_if.sv
// Bus bundle between the EX/MEM request source, the load/store unit and data_memory.
// Handshake: a request transfers on a rising clk edge where req_valid & req_ready are both high;
// the source holds all req_* fields stable while req_valid is high and req_ready is low.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we;
    logic        dmem_re;
    logic [31:0] dmem_rdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        err;
    logic [31:0] err_addr;

    logic        dbg_state;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, dmem_rdata,
        output req_ready, dmem_addr, dmem_wdata, dmem_we, dmem_re,
               resp_valid, resp_rdata, err, err_addr, dbg_state
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, dmem_rdata,
        input  req_ready, dmem_addr, dmem_wdata, dmem_we, dmem_re,
               resp_valid, resp_rdata, err, err_addr, dbg_state
    );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store front end for a word-write-only data_memory.
// Sub-word stores become a read-modify-write pair that stalls the pipeline one cycle.
module load_store_unit #(
    parameter int DMEM_BYTES   = 128,
    parameter bit STRICT_ALIGN = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    load_store_unit_if.slave bus
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] RMW_WR = 1'b1;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [31:0] ADDR_MAX = 32'(DMEM_BYTES - 4);

    logic [0:0]  state;
    logic [31:0] addr_q;
    logic [31:0] merge_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        err_q;
    logic [31:0] err_addr_q;

    logic accept;
    logic funct_ok;
    logic range_ok;
    logic align_ok;
    logic legal;
    logic is_subword_store;

    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] r;
        case (f3)
            F3_B:    r = {{24{w[7]}}, w[7:0]};
            F3_H:    r = {{16{w[15]}}, w[15:0]};
            F3_BU:   r = {24'd0, w[7:0]};
            F3_HU:   r = {16'd0, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    assign bus.req_ready = (state == IDLE) & rstn;
    assign accept        = bus.req_valid & bus.req_ready;

    always_comb begin
        funct_ok = 1'b0;
        case (bus.req_funct3)
            F3_B, F3_H, F3_W: funct_ok = 1'b1;
            F3_BU, F3_HU:     funct_ok = ~bus.req_write;
            default:          funct_ok = 1'b0;
        endcase
    end

    // Full 32-bit compare so any high address bit makes the request illegal.
    assign range_ok = (bus.req_addr <= ADDR_MAX);

    always_comb begin
        align_ok = 1'b1;
        if (STRICT_ALIGN) begin
            case (bus.req_funct3[1:0])
                2'b10:   align_ok = (bus.req_addr[1:0] == 2'b00);
                2'b01:   align_ok = ~bus.req_addr[0];
                default: align_ok = 1'b1;
            endcase
        end
    end

    assign legal            = funct_ok & range_ok & align_ok;
    assign is_subword_store = bus.req_write & (bus.req_funct3 != F3_W);

    always_comb begin
        bus.dmem_addr  = 32'd0;
        bus.dmem_wdata = 32'd0;
        bus.dmem_we    = 1'b0;
        bus.dmem_re    = 1'b0;
        if (rstn) begin
            if (state == RMW_WR) begin
                bus.dmem_we    = 1'b1;
                bus.dmem_addr  = addr_q;
                bus.dmem_wdata = merge_q;
            end else if (accept && legal) begin
                bus.dmem_addr = bus.req_addr;
                if (bus.req_write && !is_subword_store) begin
                    bus.dmem_we    = 1'b1;
                    bus.dmem_wdata = bus.req_wdata;
                end else begin
                    bus.dmem_re = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            addr_q       <= 32'd0;
            merge_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            err_q        <= 1'b0;
            err_addr_q   <= 32'd0;
        end else begin
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!legal) begin
                            err_q      <= 1'b1;
                            err_addr_q <= bus.req_addr;
                        end else if (!bus.req_write) begin
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= extend_load(bus.req_funct3, bus.dmem_rdata);
                        end else if (is_subword_store) begin
                            // Keep the untouched upper bytes from the word read this cycle.
                            if (bus.req_funct3 == F3_B)
                                merge_q <= {bus.dmem_rdata[31:8], bus.req_wdata[7:0]};
                            else
                                merge_q <= {bus.dmem_rdata[31:16], bus.req_wdata[15:0]};
                            addr_q <= bus.req_addr;
                            state  <= RMW_WR;
                        end
                    end
                end
                RMW_WR:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.err        = err_q;
    assign bus.err_addr   = err_addr_q;
    assign bus.dbg_state  = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and random load/store traffic against a byte-array reference of data_memory.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit #(.DMEM_BYTES(128), .STRICT_ALIGN(1'b1)) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  // data_memory stand-in: combinational read, word write on the rising edge, cleared by reset
  logic [7:0] dmem [0:127];
  logic [7:0] ref_mem [0:127];
  int passes = 0;
  int total = 0;

  always_comb begin
    bus.dmem_rdata = 32'd0;
    if (bus.dmem_addr <= 32'd124)
      bus.dmem_rdata = {dmem[bus.dmem_addr[6:0] + 7'd3], dmem[bus.dmem_addr[6:0] + 7'd2],
                        dmem[bus.dmem_addr[6:0] + 7'd1], dmem[bus.dmem_addr[6:0]]};
  end

  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 128; i++) dmem[i] <= 8'd0;
    end else if (bus.dmem_we && bus.dmem_addr <= 32'd124) begin
      dmem[bus.dmem_addr[6:0]]         <= bus.dmem_wdata[7:0];
      dmem[bus.dmem_addr[6:0] + 7'd1]  <= bus.dmem_wdata[15:8];
      dmem[bus.dmem_addr[6:0] + 7'd2]  <= bus.dmem_wdata[23:16];
      dmem[bus.dmem_addr[6:0] + 7'd3]  <= bus.dmem_wdata[31:24];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int access_bytes(input logic [2:0] f3);
    return 1 << int'(f3 % 3'd4);
  endfunction

  function automatic bit model_legal(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    bit f_ok;
    f_ok = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!f_ok) return 1'b0;
    if (a > 32'd124) return 1'b0;
    return (a % access_bytes(f3)) == 0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'(a);
    return {ref_mem[b + 3], ref_mem[b + 2], ref_mem[b + 1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] w);
    logic [31:0] lo;
    case (f3)
      3'd0: begin lo = w % 256;   return (lo >= 128)   ? lo + 32'hFFFF_FF00 : lo; end
      3'd1: begin lo = w % 65536; return (lo >= 32768) ? lo + 32'hFFFF_0000 : lo; end
      3'd4: return w % 256;
      3'd5: return w % 65536;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] old,
                                              input logic [31:0] wd);
    logic [31:0] mask;
    mask = (access_bytes(f3) == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * access_bytes(f3))) - 32'd1;
    return (old & ~mask) | (wd & mask);
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input string tag);
    bit legal;
    bit sub;
    logic [31:0] merged;
    legal = model_legal(wr, f3, a);
    sub = wr && (f3 != 3'd2);
    merged = 32'd0;
    if (legal && wr) merged = model_store(f3, ref_word(a), wd);

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_funct3 = f3;
    bus.req_addr = a;
    bus.req_wdata = wd;
    #1;
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, ".we"}, 32'(bus.dmem_we), 32'(legal && wr && !sub));
    chk({tag, ".re"}, 32'(bus.dmem_re), 32'(legal && (!wr || sub)));
    if (legal && wr && !sub) chk({tag, ".wdata"}, bus.dmem_wdata, wd);

    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'(legal && !wr));
    chk({tag, ".err"}, 32'(bus.err), 32'(!legal));
    if (!legal) chk({tag, ".err_addr"}, bus.err_addr, a);
    if (legal && !wr) chk({tag, ".rdata"}, bus.resp_rdata, model_load(f3, ref_word(a)));

    if (legal && wr) begin
      for (int k = 0; k < 4; k++) ref_mem[int'(a) + k] = merged[8*k +: 8];
    end
    if (legal && sub) begin
      chk({tag, ".rmw_ready"}, 32'(bus.req_ready), 32'd0);
      chk({tag, ".rmw_state"}, 32'(bus.dbg_state), 32'd1);
      chk({tag, ".rmw_we"}, 32'(bus.dmem_we), 32'd1);
      chk({tag, ".rmw_addr"}, bus.dmem_addr, a);
      chk({tag, ".rmw_wdata"}, bus.dmem_wdata, merged);
      @(posedge clk);
      #1;
      chk({tag, ".rmw_done"}, 32'({bus.resp_valid, bus.err}), 32'd0);
    end
  endtask

  initial begin
    bit wr;
    logic [2:0] f3;
    logic [31:0] a;
    logic [2:0] legal_f3 [5];
    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'd0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 32'(bus.req_ready), 32'd0);
    chk("rst.we", 32'(bus.dmem_we), 32'd0);
    chk("rst.re", 32'(bus.dmem_re), 32'd0);
    chk("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst.resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst.err", 32'(bus.err), 32'd0);
    chk("rst.err_addr", bus.err_addr, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // directed
    issue(1'b1, 3'd2, 32'd8, 32'hDEADBEEF, "sw8");
    issue(1'b0, 3'd2, 32'd8, 32'd0, "lw8");
    chk("lw8.value", bus.resp_rdata, 32'hDEADBEEF);
    issue(1'b1, 3'd0, 32'd8, 32'h0000_0011, "sb8");
    issue(1'b0, 3'd2, 32'd8, 32'd0, "lw8b");
    chk("lw8b.value", bus.resp_rdata, 32'hDEADBE11);
    issue(1'b1, 3'd2, 32'd4, 32'h0000_F080, "sw4");
    issue(1'b0, 3'd0, 32'd4, 32'd0, "lb4");
    chk("lb4.value", bus.resp_rdata, 32'hFFFF_FF80);
    issue(1'b0, 3'd4, 32'd4, 32'd0, "lbu4");
    chk("lbu4.value", bus.resp_rdata, 32'h0000_0080);
    issue(1'b0, 3'd1, 32'd4, 32'd0, "lh4");
    chk("lh4.value", bus.resp_rdata, 32'hFFFF_F080);
    issue(1'b0, 3'd5, 32'd4, 32'd0, "lhu4");
    chk("lhu4.value", bus.resp_rdata, 32'h0000_F080);
    issue(1'b0, 3'd2, 32'd6, 32'd0, "lw6_misalign");
    issue(1'b1, 3'd1, 32'd3, 32'h55, "sh3_misalign");
    issue(1'b0, 3'd2, 32'h200, 32'd0, "lw200_range");
    issue(1'b0, 3'd3, 32'd0, 32'd0, "f3_3");
    issue(1'b0, 3'd2, 32'd124, 32'd0, "lw124_edge");
    issue(1'b0, 3'd2, 32'd125, 32'd0, "lw125_over");
    issue(1'b0, 3'd0, 32'h8000_0000, 32'd0, "lb_highbit");
    issue(1'b1, 3'd4, 32'd0, 32'd0, "sbu_illegal");

    // random traffic
    for (int n = 0; n < 120; n++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) f3 = legal_f3[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) a = $urandom() | 32'h100;
      else a = 32'($urandom_range(0, 127));
      issue(wr, f3, a, $urandom(), "rand");
    end

    // reset in the RMW write cycle
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_funct3 = 3'd1;
    bus.req_addr = 32'd12;
    bus.req_wdata = 32'h0000_AAAA;
    #1;
    chk("rstmid.re", 32'(bus.dmem_re), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("rstmid.state", 32'(bus.dbg_state), 32'd1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rstmid.we", 32'(bus.dmem_we), 32'd0);
    chk("rstmid.ready_low", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rstmid.resp_err", 32'({bus.resp_valid, bus.err}), 32'd0);
    chk("rstmid.state_idle", 32'(bus.dbg_state), 32'd0);
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'd0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rstmid.ready", 32'(bus.req_ready), 32'd1);
    issue(1'b0, 3'd2, 32'd12, 32'd0, "rstmid.lw12");

    // back-to-back sub-word store then load
    issue(1'b1, 3'd1, 32'd16, 32'h0000_1234, "b2b.sh16");
    issue(1'b0, 3'd5, 32'd16, 32'd0, "b2b.lhu16");
    chk("b2b.value", bus.resp_rdata, 32'h0000_1234);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
